// File: rtl/bip_datapath.sv
// ---------------------------------------------------------------------------
// bip_datapath
// Execution datapath of the BIP processor: accumulator, add/sub ALU, A/B
// operand muxes and a data RAM with a registered read port. Memory-read
// instructions take two cycles. o_stall asks the control unit to hold its
// PC and instruction during the first of those two cycles.
//
// Ports
//   i_clock     system clock, rising edge
//   i_reset     asynchronous active-low reset
//   i_valid     control bundle valid
//   i_sel_a     acc source: 0=RAM data, 1=ALU, 2=imm, 3=reserved (hold)
//   i_sel_b     ALU B operand: 0=RAM data, 1=imm
//   i_wr_acc    load accumulator
//   i_op        ALU op: 0=add, 1=sub
//   i_wr_ram    store accumulator to RAM[addr]
//   i_rd_ram    read RAM[addr]
//   i_operand   immediate / data address
//   o_acc       accumulator value
//   o_stall     hold request to control unit (combinational)
//   o_overflow  sticky signed overflow flag
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accepting instructions; reads are issued from here
// WAIT_RD  | RAM read data valid; variable-operand instruction completes
// ---------------------------------------------------------------------------
module bip_datapath #(
  parameter int NB_DATA          = 16,
  parameter int NB_OPERAND       = 11,
  parameter int N_DATA_ADDR      = 1024,
  parameter int LOG2_N_DATA_ADDR = 10,
  parameter int NB_SEL_A         = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NB_SEL_A-1:0]   i_sel_a,
  input  logic                  i_sel_b,
  input  logic                  i_wr_acc,
  input  logic                  i_op,
  input  logic                  i_wr_ram,
  input  logic                  i_rd_ram,
  input  logic [NB_OPERAND-1:0] i_operand,
  output logic [NB_DATA-1:0]    o_acc,
  output logic                  o_stall,
  output logic                  o_overflow
);

  typedef enum logic {IDLE = 1'b0, WAIT_RD = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [NB_DATA-1:0]          r_acc;
  logic                        r_overflow;
  logic [NB_DATA-1:0]          r_ram [N_DATA_ADDR];
  logic [NB_DATA-1:0]          r_rd_data;

  logic [LOG2_N_DATA_ADDR-1:0] w_addr;
  logic [NB_DATA-1:0]          w_imm;
  logic [NB_DATA-1:0]          w_alu_b;
  logic [NB_DATA-1:0]          w_alu;
  logic                        w_alu_ovf;
  logic                        w_ram_we;
  logic                        w_rd_issue;
  logic                        w_acc_we;
  logic [NB_DATA-1:0]          w_acc_next;
  logic                        w_ovf_set;

  assign w_addr  = i_operand[LOG2_N_DATA_ADDR-1:0];
  assign w_imm   = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  assign w_alu_b = i_sel_b ? w_imm : r_rd_data;
  assign w_alu   = i_op ? (r_acc - w_alu_b) : (r_acc + w_alu_b);

  // Sub overflows when operand signs differ, add when they match; in both
  // cases the result sign must have moved away from the accumulator sign.
  assign w_alu_ovf = (i_op ? (r_acc[NB_DATA-1] != w_alu_b[NB_DATA-1])
                           : (r_acc[NB_DATA-1] == w_alu_b[NB_DATA-1]))
                     && (w_alu[NB_DATA-1] != r_acc[NB_DATA-1]);

  // A simultaneous write strobe suppresses the read.
  assign w_ram_we   = (r_state == IDLE) && i_valid && i_wr_ram;
  assign w_rd_issue = (r_state == IDLE) && i_valid && i_rd_ram && !i_wr_ram;

  // Gated by reset so the request drops at once while reset is held, even
  // if the control unit keeps presenting a read.
  assign o_stall = i_reset && w_rd_issue;

  always_comb begin
    w_state_next = r_state;
    w_acc_we     = 1'b0;
    w_acc_next   = r_acc;
    w_ovf_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_issue) begin
          w_state_next = WAIT_RD;
        end else if (i_valid && !i_wr_ram && !i_rd_ram && i_wr_acc) begin
          // RAM-sourced paths have no valid data here: those combinations hold.
          case (i_sel_a)
            2'd1: begin
              if (i_sel_b) begin
                w_acc_we   = 1'b1;
                w_acc_next = w_alu;
                w_ovf_set  = w_alu_ovf;
              end
            end
            2'd2: begin
              w_acc_we   = 1'b1;
              w_acc_next = w_imm;
            end
            default: ;
          endcase
        end
      end
      WAIT_RD: begin
        // Inputs are held by the control unit, so i_valid is not consulted.
        w_state_next = IDLE;
        if (i_wr_acc) begin
          case (i_sel_a)
            2'd0: begin
              w_acc_we   = 1'b1;
              w_acc_next = r_rd_data;
            end
            2'd1: begin
              w_acc_we   = 1'b1;
              w_acc_next = w_alu;
              w_ovf_set  = w_alu_ovf;
            end
            2'd2: begin
              w_acc_we   = 1'b1;
              w_acc_next = w_imm;
            end
            default: ;
          endcase
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_acc_we) begin
        r_acc <= w_acc_next;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // RAM array and read register are not reset.
  always_ff @(posedge i_clock) begin
    if (w_ram_we) begin
      r_ram[w_addr] <= r_acc;
    end
    if (w_rd_issue) begin
      r_rd_data <= r_ram[w_addr];
    end
  end

  assign o_acc      = r_acc;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bip_datapath.sv
module tb_bip_datapath;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [1:0]  i_sel_a;
  logic        i_sel_b;
  logic        i_wr_acc;
  logic        i_op;
  logic        i_wr_ram;
  logic        i_rd_ram;
  logic [10:0] i_operand;
  logic [15:0] o_acc;
  logic        o_stall;
  logic        o_overflow;

  int n_vec = 0;
  int n_err = 0;

  bip_datapath dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_sel_a    (i_sel_a),
    .i_sel_b    (i_sel_b),
    .i_wr_acc   (i_wr_acc),
    .i_op       (i_op),
    .i_wr_ram   (i_wr_ram),
    .i_rd_ram   (i_rd_ram),
    .i_operand  (i_operand),
    .o_acc      (o_acc),
    .o_stall    (o_stall),
    .o_overflow (o_overflow)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sa, input logic sb, input logic wa,
                       input logic op, input logic wr, input logic rd, input logic [10:0] opnd);
    i_valid   = v;
    i_sel_a   = sa;
    i_sel_b   = sb;
    i_wr_acc  = wa;
    i_op      = op;
    i_wr_ram  = wr;
    i_rd_ram  = rd;
    i_operand = opnd;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // single-cycle instruction, no stall expected
  task automatic exec1(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                       input logic wr, input logic [10:0] opnd);
    drive(1'b1, sa, sb, wa, op, wr, 1'b0, opnd);
    #1;
    check("stall_1cyc", {31'd0, o_stall}, 32'd0);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
  endtask

  // two-cycle read instruction; checks the one-cycle stall and that acc
  // is untouched in the first cycle
  task automatic exec_rd(input logic [1:0] sa, input logic sb, input logic op,
                         input logic [10:0] opnd, input logic [15:0] acc_before);
    drive(1'b1, sa, sb, 1'b1, op, 1'b0, 1'b1, opnd);
    #1;
    check("stall_rd_c1", {31'd0, o_stall}, 32'd1);
    tick();
    check("stall_rd_c2", {31'd0, o_stall}, 32'd0);
    check("acc_rd_c1", {16'd0, o_acc}, {16'd0, acc_before});
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
  endtask

  initial begin
    i_reset = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    #12;
    check("rst_acc", {16'd0, o_acc}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    i_reset = 1'b1;
    tick();

    // load immediate -5
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h7FB);
    check("ldi_neg5", {16'd0, o_acc}, 32'h0000_FFFB);

    // build 0x1234: 0x234 then subtract -1024 four times
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h234);
    for (int i = 0; i < 4; i++) exec1(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 11'h400);
    check("build_1234", {16'd0, o_acc}, 32'h0000_1234);
    check("build_ovf", {31'd0, o_overflow}, 32'd0);

    // store to addr 5, clear acc, load back
    exec1(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd5);
    check("st_acc_keep", {16'd0, o_acc}, 32'h0000_1234);
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    check("ldi_0", {16'd0, o_acc}, 32'd0);
    exec_rd(2'd0, 1'b0, 1'b0, 11'd5, 16'h0000);
    check("ld_var_5", {16'd0, o_acc}, 32'h0000_1234);
    #1;
    check("idle_stall", {31'd0, o_stall}, 32'd0);

    // sel_a=3 and RAM-sourced without read both hold
    exec1(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 11'h011);
    check("sela3_hold", {16'd0, o_acc}, 32'h0000_1234);
    exec1(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h011);
    check("sela0_nord_hold", {16'd0, o_acc}, 32'h0000_1234);

    // climb to 0x7FFF: 31 + 32*1023
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'd31);
    for (int i = 0; i < 32; i++) exec1(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1023);
    check("acc_7fff", {16'd0, o_acc}, 32'h0000_7FFF);
    check("ovf_pre", {31'd0, o_overflow}, 32'd0);
    exec1(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1);
    check("addi_wrap", {16'd0, o_acc}, 32'h0000_8000);
    check("addi_ovf", {31'd0, o_overflow}, 32'd1);
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    check("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // reset during WAIT_RD
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'd7);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd5);
    #1;
    check("rstrd_stall_c1", {31'd0, o_stall}, 32'd1);
    tick();
    #2;
    i_reset = 1'b0;
    #1;
    check("rstrd_acc", {16'd0, o_acc}, 32'd0);
    check("rstrd_stall", {31'd0, o_stall}, 32'd0);
    check("rstrd_ovf", {31'd0, o_overflow}, 32'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    tick();
    i_reset = 1'b1;
    tick();
    check("post_rst_stall", {31'd0, o_stall}, 32'd0);
    exec_rd(2'd0, 1'b0, 1'b0, 11'd5, 16'h0000);
    check("ram5_intact", {16'd0, o_acc}, 32'h0000_1234);

    // subtract variable: RAM[3]=0x10, acc=5, acc-RAM[3]
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'h010);
    exec1(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd3);
    exec1(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5);
    exec_rd(2'd1, 1'b0, 1'b1, 11'd3, 16'h0005);
    check("subv_acc", {16'd0, o_acc}, 32'h0000_FFF5);
    check("subv_ovf", {31'd0, o_overflow}, 32'd0);

    // valid gating: nothing moves for 3 cycles
    drive(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gate_stall", {31'd0, o_stall}, 32'd0);
      tick();
      check("gate_acc", {16'd0, o_acc}, 32'h0000_FFF5);
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    exec_rd(2'd0, 1'b0, 1'b0, 11'd3, 16'hFFF5);
    check("gate_ram3", {16'd0, o_acc}, 32'h0000_0010);

    // add variable with RAM[5]: 0x10 + 0x1234
    exec_rd(2'd1, 1'b0, 1'b0, 11'd5, 16'h0010);
    check("addv_acc", {16'd0, o_acc}, 32'h0000_1244);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
- Execution datapath of the BIP processor. It sits directly downstream of the BIP control unit and consumes that unit's per-instruction control bundle and operand field.
- It contains the accumulator, the add/sub ALU, the A/B operand muxes and the data RAM.
- The data RAM has a registered read port. Memory-read instructions therefore take two cycles; during the first cycle the block raises o_stall so the control unit holds its PC and instruction.

Parameters:
- NB_DATA, 16, accumulator/ALU/RAM word width
- NB_OPERAND, 11, instruction operand field width
- N_DATA_ADDR, 1024, data RAM depth in words
- LOG2_N_DATA_ADDR, 10, data RAM address width
- NB_SEL_A, 2, width of accumulator-source select

Ports:
- i_clock  in  1  single system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  control bundle valid this cycle
- i_sel_a  in  NB_SEL_A  acc source: 0=RAM read data, 1=ALU result, 2=sign-extended operand, 3=reserved
- i_sel_b  in  1  ALU B operand: 0=RAM read data, 1=sign-extended operand
- i_wr_acc  in  1  load accumulator
- i_op  in  1  ALU op: 0=add (acc+B), 1=sub (acc-B)
- i_wr_ram  in  1  store accumulator to RAM[addr]
- i_rd_ram  in  1  read RAM[addr]
- i_operand  in  NB_OPERAND  immediate / data address
- o_acc  out  NB_DATA  accumulator value
- o_stall  out  1  hold request to control unit (combinational)
- o_overflow  out  1  sticky signed overflow flag

Behaviour:
- Reset (i_reset=0, async): acc=0, o_overflow=0, FSM=IDLE, o_stall=0. RAM contents are not reset.
- Reset mid-operation, including in WAIT_RD: the read is aborted, FSM→IDLE, acc=0.
- addr = i_operand[LOG2_N_DATA_ADDR-1:0]. i_operand[10] is ignored for addressing.
- imm = i_operand sign-extended to NB_DATA.
- ALU result is modulo 2^NB_DATA, wrapping. Signed overflow = operands have equal sign (add) or differing sign (sub), and the result sign differs from the acc sign.
- FSM IDLE:
  - i_valid=0: no state change; o_stall=0.
  - i_valid=1, i_wr_ram=1: RAM[addr]<=acc at the rising edge, single cycle, no stall. If i_rd_ram=1 at the same time, the combination is illegal; the write wins and the read is ignored.
  - i_valid=1, i_rd_ram=1, i_wr_ram=0: RAM read is issued; o_stall=1 in this same cycle; acc is not written; next state WAIT_RD.
  - i_valid=1, neither RAM strobe: if i_wr_acc=1, acc is updated at the edge from the sel_a source. sel_a=0 or sel_b=0 without i_rd_ram is illegal; acc holds.
- FSM WAIT_RD:
  - RAM data is valid; o_stall=0.
  - If i_wr_acc=1, acc is updated using RAM data for the sel_a=0 or sel_b=0 paths.
  - Next state IDLE unconditionally. The update completes even if i_valid drops, because the control unit is required to hold its inputs stable while o_stall=1.
- sel_a=3 with i_wr_acc=1: acc holds.
- o_overflow is set on any acc write via sel_a=1 whose ALU result overflows. It stays set until reset.
- Latency:
  - immediate and ALU-immediate instructions: 1 cycle
  - store: 1 cycle
  - load-variable and ALU-variable instructions: 2 cycles, with o_stall high for exactly 1 cycle
- o_acc is driven directly from the register.

Test Plan:
- Load immediate: i_valid=1, sel_a=2, wr_acc=1, operand=11'h7FB (-5) → o_acc=16'hFFFB next cycle; o_stall stays 0.
- Store/load round trip:
  - acc=16'h1234; issue wr_ram at addr 5.
  - Then load-immediate 0.
  - Then rd_ram + sel_a=0 + wr_acc at addr 5.
  - Expected: o_stall=1 for one cycle, then o_acc=16'h1234; FSM back in IDLE.
- Add-immediate overflow: acc=16'h7FFF, sel_a=1, sel_b=1, op=0, operand=1 → o_acc=16'h8000, o_overflow=1. A following load-immediate 0 leaves o_overflow=1.
- Subtract variable: RAM[3]=16'h0010, acc=16'h0005; rd_ram, sel_a=1, sel_b=0, op=1 → after 2 cycles o_acc=16'hFFF5, o_overflow=0.
- Reset in WAIT_RD: drop i_reset low asynchronously in the stall's second cycle → o_acc=0 and o_stall=0 immediately. After release, the FSM is in IDLE and RAM[addr] is unchanged.
- Valid gating: i_valid=0 with wr_acc=1 and wr_ram=1 for 3 cycles → acc and RAM unchanged, o_stall=0 throughout.
